// File: rtl/stc_pkg.sv
// Shared constants and helpers for the serial two's-complement negator.
// Optional feature macro used by the design: STC_OVF_EN (per-lane overflow detect).
package stc_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  // Word phase decoded from the shared bit counter
  typedef enum logic [1:0] {
    PH_FIRST = 2'd0,
    PH_MID   = 2'd1,
    PH_LAST  = 2'd2
  } phase_e;

  // Bit-counter width for a word of the given size
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // LSB position of a lane inside the packed parallel-word bus
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/stc_lane.sv
// Single-lane serial negator cell: pass/negate one LSB-first bit stream,
// assemble the completed word and (with STC_OVF_EN) flag most-negative input.
module stc_lane
  import stc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_acc,
  input  logic             i_first,
  input  logic             i_last,
  input  logic             i_bit,
  input  logic             i_neg_mask,
  output logic             o_bit,
  output logic [WIDTH-1:0] o_word,
  output logic             o_ovf
);

  logic             r_neg;
  logic             r_seen;
  logic             r_bit;
  logic [WIDTH-2:0] r_hold;
  logic [WIDTH-1:0] r_word;

  logic             w_neg;
  logic             w_seen_prev;
  logic             w_res;
  logic [WIDTH-1:0] w_shift;

  // Word-start overrides: fresh mask and cleared seen flag on the first bit
  always_comb begin
    w_neg       = i_first ? i_neg_mask : r_neg;
    w_seen_prev = i_first ? 1'b0 : r_seen;
    w_res       = (w_neg & w_seen_prev) ? ~i_bit : i_bit;
    w_shift     = {w_res, r_hold};
  end

  // Lane state: mask, seen flag, result bit, holding shifter and committed word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg  <= 1'b0;
      r_seen <= 1'b0;
      r_bit  <= 1'b0;
      r_hold <= '0;
      r_word <= '0;
    end else if (i_acc) begin
      r_neg  <= w_neg;
      r_seen <= w_seen_prev | i_bit;
      r_bit  <= w_res;
      r_hold <= w_shift[WIDTH-1:1];
      if (i_last) begin
        r_word <= w_shift;
      end
    end
  end

  assign o_bit  = r_bit;
  assign o_word = r_word;

`ifdef STC_OVF_EN
  logic r_ovf;

  // Overflow: negating a word whose only 1 is its final bit (most-negative value)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (i_acc && i_last) begin
      r_ovf <= w_neg & i_bit & ~w_seen_prev;
    end
  end

  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/serial_twos_comp_n.sv
// Multi-channel word-framed serial two's-complement negator, LSB first.
// Owns the shared bit counter and framing outputs; one stc_lane per channel.
// Optional: define STC_OVF_EN to build per-lane overflow detection (ovf tied 0 otherwise).
module serial_twos_comp_n
  import stc_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS
) (
  input  logic                      t_clock,
  input  logic                      r,
  input  logic                      in_valid,
  input  logic [CHANNELS-1:0]       in_bit,
  input  logic [CHANNELS-1:0]       neg_mask,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       out_bit,
  output logic                      word_done,
  output logic [CHANNELS*WIDTH-1:0] out_word,
  output logic [CHANNELS-1:0]       ovf
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_word_done;

  logic [CNT_W-1:0] w_cnt_next;
  phase_e           w_phase;
  logic             w_first;
  logic             w_last;

  // Decode word phase from the counter
  always_comb begin
    w_phase = PH_MID;
    if (r_cnt == '0) begin
      w_phase = PH_FIRST;
    end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
      w_phase = PH_LAST;
    end
    w_first = (w_phase == PH_FIRST);
    w_last  = (w_phase == PH_LAST);
  end

  // Next counter value: advance on accepted bits, wrap after the last bit
  always_comb begin
    w_cnt_next = r_cnt;
    if (in_valid) begin
      w_cnt_next = w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Shared counter and framing flags
  always_ff @(posedge t_clock) begin
    if (r) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_out_valid <= in_valid;
      r_word_done <= in_valid & w_last;
    end
  end

  assign out_valid = r_out_valid;
  assign word_done = r_word_done;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    stc_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk        (t_clock),
      .rst        (r),
      .i_acc      (in_valid),
      .i_first    (w_first),
      .i_last     (w_last),
      .i_bit      (in_bit[k]),
      .i_neg_mask (neg_mask[k]),
      .o_bit      (out_bit[k]),
      .o_word     (out_word[lane_lsb(k, WIDTH) +: WIDTH]),
      .o_ovf      (ovf[k])
    );
  end

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Self-checking bench for serial_twos_comp_n (WIDTH=8, CHANNELS=4) against an
// arithmetic negation reference model.
module tb_serial_twos_comp_n;

  localparam int W  = 8;
  localparam int CH = 4;

  logic            t_clock;
  logic            r;
  logic            in_valid;
  logic [CH-1:0]   in_bit;
  logic [CH-1:0]   neg_mask;
  logic            out_valid;
  logic [CH-1:0]   out_bit;
  logic            word_done;
  logic [CH*W-1:0] out_word;
  logic [CH-1:0]   ovf;

  int n_checks;
  int n_pass;
  int cyc;
  int last_done_cyc;

  logic [CH-1:0]   last_bits;
  logic [CH*W-1:0] prev_word;
  logic [CH-1:0]   prev_ovf;

  serial_twos_comp_n #(.WIDTH(W), .CHANNELS(CH)) dut (
    .t_clock   (t_clock),
    .r         (r),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .neg_mask  (neg_mask),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .word_done (word_done),
    .out_word  (out_word),
    .ovf       (ovf)
  );

  initial t_clock = 1'b0;
  always #5 t_clock = ~t_clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: per-lane arithmetic negation modulo 2^W
  function automatic logic [CH*W-1:0] model_word(input logic [CH*W-1:0] words, input logic [CH-1:0] mask);
    logic [CH*W-1:0] res;
    logic [W-1:0] x;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      x = words[k*W +: W];
      res[k*W +: W] = mask[k] ? W'(0) - x : x;
    end
    return res;
  endfunction

  // Reference: negating the most-negative value overflows
  function automatic logic [CH-1:0] model_ovf(input logic [CH*W-1:0] words, input logic [CH-1:0] mask);
    logic [CH-1:0] o;
    o = '0;
`ifdef STC_OVF_EN
    for (int k = 0; k < CH; k++)
      o[k] = mask[k] && (words[k*W +: W] == (W'(1) << (W - 1)));
`else
    if (words == '1 && mask == '1) o = '0;
`endif
    return o;
  endfunction

  task automatic tick();
    @(posedge t_clock);
    #1;
    cyc++;
  endtask

  task automatic stall(input int n);
    for (int s = 0; s < n; s++) begin
      in_valid = 1'b0;
      in_bit   = CH'($urandom);
      neg_mask = CH'($urandom);
      tick();
      chk("stall_out_valid", 64'(out_valid), 64'd0);
      chk("stall_word_done", 64'(word_done), 64'd0);
      chk("stall_out_bit",   64'(out_bit), 64'(last_bits));
      chk("stall_out_word",  64'(out_word), 64'(prev_word));
    end
  endtask

  task automatic send_word(input logic [CH*W-1:0] words, input logic [CH-1:0] mask,
                           input int gap_after, input int gap_len, input bit rnd_stall);
    logic [CH*W-1:0] exp_w;
    logic [CH-1:0]   exp_o;
    logic [CH-1:0]   exp_b;
    exp_w = model_word(words, mask);
    exp_o = model_ovf(words, mask);
    for (int i = 0; i < W; i++) begin
      if (rnd_stall && $urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 2)));
      in_valid = 1'b1;
      for (int k = 0; k < CH; k++) in_bit[k] = words[k*W + i];
      neg_mask = (i == 0) ? mask : CH'($urandom);
      tick();
      for (int k = 0; k < CH; k++) exp_b[k] = exp_w[k*W + i];
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_bit",   64'(out_bit), 64'(exp_b));
      chk("word_done", 64'(word_done), 64'(i == W - 1));
      last_bits = exp_b;
      if (i == W - 1) begin
        prev_word     = exp_w;
        prev_ovf      = exp_o;
        last_done_cyc = cyc;
      end
      chk("out_word", 64'(out_word), 64'(prev_word));
      chk("ovf",      64'(ovf), 64'(prev_ovf));
      if (i == gap_after) stall(gap_len);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int first_done;
    n_checks = 0; n_pass = 0; cyc = 0; last_done_cyc = 0;
    last_bits = '0; prev_word = '0; prev_ovf = '0;
    r = 1'b1; in_valid = 1'b0; in_bit = '0; neg_mask = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_bit",   64'(out_bit), 64'd0);
    chk("rst_word_done", 64'(word_done), 64'd0);
    chk("rst_out_word",  64'(out_word), 64'd0);
    chk("rst_ovf",       64'(ovf), 64'd0);
    r = 1'b0;
    stall(2);

    // 1: lane0 negate 0x06 -> 0xFA
    send_word(32'h0000_0006, 4'b0001, -1, 0, 1'b0);
    chk("t1_lane0", 64'(out_word[7:0]), 64'hFA);
    // 2: all lanes negate, edge values
    send_word({8'h7F, 8'h80, 8'h00, 8'h01}, 4'b1111, -1, 0, 1'b0);
    chk("t2_word", 64'(out_word), 64'h8180_00FF);
    // 3: lane1 pass with mask toggling mid-word, then negate
    send_word(32'h0000_5A00, 4'b0000, -1, 0, 1'b0);
    chk("t3_pass", 64'(out_word[15:8]), 64'h5A);
    send_word(32'h0000_5A00, 4'b0010, -1, 0, 1'b0);
    chk("t3_neg", 64'(out_word[15:8]), 64'hA6);
    // 4: three-cycle stall between bits 3 and 4
    send_word(32'h0000_0006, 4'b0001, 3, 3, 1'b0);
    chk("t4_lane0", 64'(out_word[7:0]), 64'hFA);
    stall(1);

    // 5: reset after bit 4 discards the partial word
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = CH'($urandom); neg_mask = 4'hF;
      tick();
    end
    r = 1'b1; in_valid = 1'b1; in_bit = '1;
    tick();
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_bit",   64'(out_bit), 64'd0);
    chk("t5_word_done", 64'(word_done), 64'd0);
    chk("t5_out_word",  64'(out_word), 64'd0);
    chk("t5_ovf",       64'(ovf), 64'd0);
    r = 1'b0; in_valid = 1'b0;
    last_bits = '0; prev_word = '0; prev_ovf = '0;
    stall(1);
    send_word(32'h0101_0101, 4'b1111, -1, 0, 1'b0);
    chk("t5_word", 64'(out_word), 64'hFFFF_FFFF);

    // 6: back-to-back words, no gap
    send_word(32'h8080_8080, 4'b1111, -1, 0, 1'b0);
    first_done = last_done_cyc;
    send_word(32'h0202_0202, 4'b1111, -1, 0, 1'b0);
    chk("t6_word", 64'(out_word), 64'hFEFE_FEFE);
    chk("t6_done_spacing", 64'(last_done_cyc - first_done), 64'd8);

    // Random words, masks and stalls
    for (int n = 0; n < 40; n++) begin
      logic [CH*W-1:0] wv;
      wv = $urandom;
      if ($urandom_range(0, 4) == 0) wv[8 +: 8] = 8'h80;
      if ($urandom_range(0, 4) == 0) wv[0 +: 8] = 8'h00;
      send_word(wv, CH'($urandom), -1, 0, 1'b1);
    end
    stall(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
